seven_seg_scanner: RTL and testbench

- Parametrised time-multiplexed seven-segment controller for NUM_DIGITS common-anode digits.
- Adds the following:
  - double-buffered digit data, committed only at frame boundaries (tear-free);
  - per-digit blank and decimal point;
  - leading-zero suppression;
  - PWM brightness.
- Sits between the SPI/data logic and the board display pins, and replaces the fixed 8-digit scanner.

---
 rtl/seven_seg_scanner.sv | 228 ++++++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed controller for NUM_DIGITS common-anode seven-segment digits.
// A free-running prescaler divides each digit slot into 2^SLOT_LOG2 cycles. The
// scan index steps once per slot. New digit data goes into a pending buffer.
// It is copied into the active (displayed) buffer only when the index wraps, so
// a frame never shows a mix of old and new data. The module also provides
// per-digit blanking, per-digit decimal points, leading-zero suppression and
// PWM dimming.
//
// Parameters:
//   NUM_DIGITS  number of multiplexed digits (2..16)
//   SLOT_LOG2   log2 of clock cycles per digit slot
//   BRIGHT_W    brightness width (must not exceed SLOT_LOG2)
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active low
//   digits_in    hex nibbles, digit k = bits [4k+3:4k], digit 0 rightmost
//   dp_in        decimal point request per digit (1 = lit)
//   blank_in     forced blank per digit (1 = dark)
//   load         strobe: capture digits_in/dp_in/blank_in into pending buffer
//   lz_suppress  leading-zero suppression enable (live)
//   brightness   PWM duty level, all-ones = full on (live)
//   seg_out      segments {g,f,e,d,c,b,a}, active low
//   dp_out       decimal point, active low
//   an_out       anode enables, active low, at most one low
//   frame_start  one-cycle pulse after the scan index wraps to 0
//   pending      high while loaded data waits for the next frame boundary
//
// Load handshake: load is a plain strobe with no back-pressure. Every cycle
// with load=1 overwrites the pending buffer, so the last load wins. pending
// reports whether the buffer still has to be committed. On a commit cycle the
// old pending contents go active, and a coincident load refills pending.
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_LOG2  = 17,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_start,
  output logic                    pending
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Hex to active-low gfedcba.
  function automatic logic [6:0] decode7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // State
  logic [SLOT_LOG2-1:0]    prescaler_q, prescaler_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  // Combinational helpers
  logic                  tick;
  logic                  wrap_tick;
  logic                  pwm_on;
  logic                  chain;
  logic [NUM_DIGITS-1:0] suppressed;
  logic [3:0]            cur_nibble;
  logic                  cur_blank;
  logic                  cur_dp;
  logic                  cur_sup;
  logic                  cur_visible;
  logic                  cur_dp_shown;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler_q   <= '0;
      index_q       <= '0;
      pending_q     <= 1'b0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      index_q       <= index_d;
      pending_q     <= pending_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Prescaler, scan index and frame pulse
  always_comb begin
    tick          = &prescaler_q;
    wrap_tick     = tick && (index_q == LAST_IDX);
    prescaler_d   = prescaler_q + 1'b1;
    index_d       = index_q;
    if (tick) begin
      index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
    end
    frame_start_d = wrap_tick;
  end

  // Pending / active buffers. The commit reads the old pending contents
  // before a coincident load overwrites them.
  always_comb begin
    pending_d     = pending_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    if (wrap_tick && pending_q) begin
      act_digits_d = pend_digits_q;
      act_dp_d     = pend_dp_q;
      act_blank_d  = pend_blank_q;
      pending_d    = 1'b0;
    end
    if (load) begin
      pend_digits_d = digits_in;
      pend_dp_d     = dp_in;
      pend_blank_d  = blank_in;
      pending_d     = 1'b1;
    end
  end

  // Leading-zero suppression. The chain runs from the leftmost digit
  // downward. A blanked digit does not stop the chain, because it shows
  // nothing. Digit 0 is always shown.
  always_comb begin
    suppressed = '0;
    chain      = lz_suppress;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      chain         = chain && ((act_digits_q[4*k +: 4] == 4'h0) || act_blank_q[k]);
      suppressed[k] = chain;
    end
  end

  // Select the digit at the current scan position.
  always_comb begin
    cur_nibble = '0;
    cur_blank  = 1'b1;
    cur_dp     = 1'b0;
    cur_sup    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (index_q == IDX_W'(k)) begin
        cur_nibble = act_digits_q[4*k +: 4];
        cur_blank  = act_blank_q[k];
        cur_dp     = act_dp_q[k];
        cur_sup    = suppressed[k];
      end
    end
  end

  // Output stage. The anode is released during the tick cycle, so the old
  // digit is dark before the index moves to the next digit.
  always_comb begin
    pwm_on       = (prescaler_q[SLOT_LOG2-1 -: BRIGHT_W] <= brightness);
    cur_visible  = !cur_blank && !cur_sup;
    cur_dp_shown = cur_dp && !cur_blank;
    seg_d        = cur_visible ? decode7(cur_nibble) : 7'h7F;
    dp_d         = !cur_dp_shown;
    an_d         = '1;
    if (!tick && pwm_on && (cur_visible || cur_dp_shown)) begin
      an_d = ~(NUM_DIGITS'(1) << index_q);
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign an_out      = an_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Bench for a 4-digit scanner with 16-cycle slots and 2-bit brightness, so one
// frame lasts 64 cycles. cyc counts clock edges since the last reset release.
// After edge n, the registered outputs show the digit slot of state n-1.
// So slot k of frame f is sampled at cyc = 64*f + 16*k + 3.
// Each load pushes the per-slot {an,seg,dp} the following frame must show.
// check_frame pops and compares them.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int SL = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4*ND-1:0] digits_in = '0;
  logic [ND-1:0] dp_in = '0;
  logic [ND-1:0] blank_in = '0;
  logic          load = 1'b0;
  logic          lz_suppress = 1'b0;
  logic [BW-1:0] brightness = 2'd3;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [ND-1:0] an_out;
  logic          frame_start;
  logic          pending;

  seven_seg_scanner #(
    .NUM_DIGITS(ND),
    .SLOT_LOG2 (SL),
    .BRIGHT_W  (BW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .lz_suppress(lz_suppress),
    .brightness (brightness),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_start(frame_start),
    .pending    (pending)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) next_cycle();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    digits_in = d;
    dp_in     = dp;
    blank_in  = bl;
    load      = 1'b1;
    next_cycle();
    load      = 1'b0;
  endtask

  task automatic push_slot(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    exp_q.push_back({an, seg, dp});
  endtask

  task automatic check_frame(input int f);
    logic [11:0] e;
    for (int k = 0; k < ND; k++) begin
      go_to(64*f + 16*k + 3);
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("frame%0d_slot%0d", f, k), {20'd0, an_out, seg_out, dp_out}, {20'd0, e});
      end
    end
  endtask

  int dark;
  int fs_cnt;
  int fs_first;
  int on_cnt;

  initial begin
    // Reset
    rst = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b1;
    cyc = 0;
    check("rst_an", an_out, 4'hF);
    check("rst_seg", seg_out, 7'h7F);
    check("rst_dp", dp_out, 1'b1);
    check("rst_pending", pending, 1'b0);
    check("rst_fs", frame_start, 1'b0);

    // Idle frames: nothing lit, one frame_start every 64 cycles
    dark = 0; fs_cnt = 0; fs_first = 0;
    while (cyc < 128) begin
      next_cycle();
      if (an_out !== 4'hF || seg_out !== 7'h7F) dark++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = cyc;
      end
    end
    check("idle_dark", dark, 0);
    check("idle_fs_count", fs_cnt, 2);
    check("idle_fs_first", fs_first, 64);
    check("idle_pending", pending, 1'b0);

    // Load mid-frame, commit at the frame boundary
    go_to(140);
    push_slot(4'hE, 7'h0E, 1'b1);
    push_slot(4'hD, 7'h08, 1'b1);
    push_slot(4'hB, 7'h24, 1'b1);
    push_slot(4'h7, 7'h79, 1'b1);
    do_load(16'h12AF, 4'h0, 4'h0);
    check("load_pending", pending, 1'b1);
    go_to(191);
    check("pre_commit_pending", pending, 1'b1);
    go_to(192);
    check("post_commit_pending", pending, 1'b0);
    check("commit_fs", frame_start, 1'b1);
    check_frame(3);

    // Load coinciding with the commit tick
    go_to(260);
    for (int k = 0; k < 4; k++) push_slot(~(4'b0001 << k), 7'h79, 1'b1);
    do_load(16'h1111, 4'h0, 4'h0);
    go_to(319);
    for (int k = 0; k < 4; k++) push_slot(~(4'b0001 << k), 7'h24, 1'b1);
    do_load(16'h2222, 4'h0, 4'h0);
    check("coincide_pending", pending, 1'b1);
    check_frame(5);
    go_to(384);
    check("coincide_drain_pending", pending, 1'b0);
    check_frame(6);

    // Leading-zero suppression
    go_to(440);
    lz_suppress = 1'b1;
    push_slot(4'hE, 7'h40, 1'b1);
    push_slot(4'hD, 7'h12, 1'b1);
    push_slot(4'hF, 7'h7F, 1'b1);
    push_slot(4'hF, 7'h7F, 1'b1);
    do_load(16'h0050, 4'h0, 4'h0);
    check_frame(7);
    go_to(500);
    push_slot(4'hE, 7'h40, 1'b1);
    push_slot(4'hF, 7'h7F, 1'b1);
    push_slot(4'hF, 7'h7F, 1'b1);
    push_slot(4'hF, 7'h7F, 1'b1);
    do_load(16'h0000, 4'h0, 4'h0);
    check_frame(8);
    // Blanked digit 3 does not stop suppression; dp shows on suppressed digit 2
    // but not on blanked digit 3.
    go_to(565);
    push_slot(4'hE, 7'h40, 1'b1);
    push_slot(4'hD, 7'h12, 1'b1);
    push_slot(4'hB, 7'h7F, 1'b0);
    push_slot(4'hF, 7'h7F, 1'b1);
    do_load(16'h3050, 4'b1100, 4'b1000);
    check_frame(9);

    // Brightness: count lit cycles in slot 0
    go_to(630);
    brightness = 2'd0;
    go_to(640);
    on_cnt = 0;
    while (cyc < 656) begin
      next_cycle();
      if (an_out == 4'hE) on_cnt++;
    end
    check("pwm_b0", on_cnt, 4);
    go_to(660);
    brightness = 2'd3;
    go_to(704);
    on_cnt = 0;
    while (cyc < 720) begin
      next_cycle();
      if (an_out == 4'hE) on_cnt++;
    end
    check("pwm_b3", on_cnt, 15);

    // Reset while data pending and displayed
    go_to(730);
    do_load(16'h1234, 4'h0, 4'h0);
    check("pre_reset_pending", pending, 1'b1);
    go_to(740);
    rst = 1'b0;
    next_cycle();
    check("midrst_an", an_out, 4'hF);
    check("midrst_seg", seg_out, 7'h7F);
    check("midrst_dp", dp_out, 1'b1);
    check("midrst_pending", pending, 1'b0);
    check("midrst_fs", frame_start, 1'b0);
    rst = 1'b1;
    cyc = 0;
    dark = 0;
    while (cyc < 150) begin
      next_cycle();
      if (an_out !== 4'hF) dark++;
    end
    push_slot(4'hE, 7'h78, 1'b1);
    push_slot(4'hF, 7'h7F, 1'b1);
    push_slot(4'hF, 7'h7F, 1'b1);
    push_slot(4'hF, 7'h7F, 1'b1);
    do_load(16'h0007, 4'h0, 4'h0);
    check("reload_pending", pending, 1'b1);
    while (cyc < 192) begin
      next_cycle();
      if (an_out !== 4'hF) dark++;
    end
    check("post_reset_dark", dark, 0);
    check("reload_commit_pending", pending, 1'b0);
    check_frame(3);

    // Report
    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
